// File: rtl/shared_reg_arb_pkg.sv
// shared_reg_arb_pkg
// Shared definitions for the shared-register write arbiter:
//   - state_t        : lock FSM states (OPEN, LOCKED)
//   - NUM_REQ_MIN/MAX: legal requester-count bounds
//   - rr_search()    : rotating first-one search used by rr_pick
package shared_reg_arb_pkg;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 16;

  // Returns {found, index}. Searches req starting at ptr and wrapping
  // modulo n, so the first set bit at or after ptr wins.
  function automatic logic [4:0] rr_search(
    input logic [NUM_REQ_MAX-1:0] req,
    input logic [3:0]             ptr,
    input int                     n
  );
    logic       found;
    logic [3:0] idx;
    int         j;
    found = 1'b0;
    idx   = 4'd0;
    for (int off = 0; off < NUM_REQ_MAX; off++) begin
      if (off < n) begin
        j = int'(ptr) + off;
        if (j >= n) j = j - n;
        if (!found && req[j[3:0]]) begin
          found = 1'b1;
          idx   = j[3:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/shared_reg_arb_rr_pick.sv
// rr_pick
// Combinational rotating-priority picker.
// Ports:
//   req  : request vector
//   ptr  : index that currently has highest priority
//   mask : bits allowed to win (all ones for plain round robin)
//   gnt  : one-hot grant, zero when nothing eligible
//   idx  : index of the granted bit
//   any  : at least one eligible request
module rr_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [4:0] res;

  assign res = rr_search(NUM_REQ_MAX'(req & mask), 4'(ptr), N);
  assign any = res[4];
  assign idx = IDX_W'(res[3:0]);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_gnt
      assign gnt[gi] = any && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/shared_reg_arb.sv
// shared_reg_arb
// Round-robin write arbiter in front of one shared data register.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req_vld   : per-requester write request
//   req_data  : flattened write data, requester i at [i*DAT_W +: DAT_W]
//   req_lock  : ownership hold request (only with SHARED_REG_ARB_LOCK_EN)
//   req_rdy   : one-hot combinational grant
//   data_out  : shared register contents
//   data_upd  : one-cycle pulse aligned with newly written data_out
//   last_src  : index of the most recent writer
// Optional feature macro: SHARED_REG_ARB_LOCK_EN adds req_lock and an
// OPEN/LOCKED FSM that lets a writer keep exclusive ownership.
module shared_reg_arb
  import shared_reg_arb_pkg::*;
#(
  parameter  int DAT_W   = 8,
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ*DAT_W-1:0] req_data,
`ifdef SHARED_REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic [NUM_REQ-1:0]       req_rdy,
  output logic [DAT_W-1:0]         data_out,
  output logic                     data_upd,
  output logic [IDX_W-1:0]         last_src
);

  logic [DAT_W-1:0]   data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   widx;
  logic               any;
  logic               write;
  logic               adv_ptr;
  logic [IDX_W-1:0]   ptr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DAT_W +: DAT_W];
    end

    // An out-of-range NUM_REQ elaborates with no picker so nothing is granted.
    if (NUM_REQ >= NUM_REQ_MIN && NUM_REQ <= NUM_REQ_MAX) begin : g_pick
      rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req  (req_vld),
        .ptr  (ptr),
        .mask (mask),
        .gnt  (gnt),
        .idx  (widx),
        .any  (any)
      );
    end else begin : g_no_pick
      assign gnt  = '0;
      assign widx = '0;
      assign any  = 1'b0;
    end
  endgenerate

  // Grants are suppressed during reset so no write can be seen as accepted.
  assign write   = any & ~rst;
  assign req_rdy = rst ? '0 : gnt;

`ifdef SHARED_REG_ARB_LOCK_EN
  state_t           state, state_next;
  logic [IDX_W-1:0] owner, owner_next;

  // Kept separate from the next-state logic: mask feeds the picker, whose
  // result feeds next-state, so merging them would form a false comb loop.
  always_comb begin
    mask = '1;
    if (state == LOCKED) begin
      mask        = '0;
      mask[owner] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    adv_ptr    = write;
    case (state)
      OPEN: begin
        if (write && req_lock[widx]) begin
          state_next = LOCKED;
          owner_next = widx;
        end
      end
      LOCKED: begin
        // Release is decided by req_lock alone; an owner write on the
        // release edge still advances the pointer.
        if (!req_lock[owner]) state_next = OPEN;
        else                  adv_ptr    = 1'b0;
      end
      default: state_next = OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OPEN;
      owner <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end
`else
  assign mask    = '1;
  assign adv_ptr = write;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      data_upd <= 1'b0;
      last_src <= '0;
      ptr      <= '0;
    end else begin
      data_upd <= write;
      if (write) begin
        data_out <= data_arr[widx];
        last_src <= widx;
      end
      if (adv_ptr) begin
        ptr <= (widx == IDX_W'(NUM_REQ - 1)) ? '0 : widx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arb.sv
// Testbench for shared_reg_arb (DAT_W=8, NUM_REQ=4). Directed vectors;
// expected writes go into a queue that a negedge monitor drains whenever
// data_upd is seen. With SHARED_REG_ARB_LOCK_EN defined the lock
// sequence is exercised as well.
module tb_shared_reg_arb;

  localparam int DAT_W   = 8;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ*DAT_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_lock;
  logic [NUM_REQ-1:0]       req_rdy;
  logic [DAT_W-1:0]         data_out;
  logic                     data_upd;
  logic [IDX_W-1:0]         last_src;

  typedef struct {
    logic [DAT_W-1:0] d;
    logic [IDX_W-1:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  shared_reg_arb #(.DAT_W(DAT_W), .NUM_REQ(NUM_REQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_data (req_data),
`ifdef SHARED_REG_ARB_LOCK_EN
    .req_lock (req_lock),
`endif
    .req_rdy  (req_rdy),
    .data_out (data_out),
    .data_upd (data_upd),
    .last_src (last_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every update pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (data_upd) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL upd_unexpected: data_out=%h last_src=%0d, no write expected",
                 data_out, last_src);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (data_out !== e.d || last_src !== e.s) begin
          bad++;
          $display("FAIL upd: got data=%h src=%0d, want data=%h src=%0d",
                   data_out, last_src, e.d, e.s);
        end else begin
          $display("upd ok: data=%h src=%0d", data_out, last_src);
        end
      end
    end
  end

  // Apply one cycle of inputs, check the combinational grant, and queue
  // the expected register update when a grant is expected.
  task automatic step(input string name, input logic r, input logic [3:0] vld,
                      input logic [31:0] data, input logic [3:0] lock,
                      input logic [3:0] exp_rdy);
    exp_t e;
    @(negedge clk);
    rst      = r;
    req_vld  = vld;
    req_data = data;
    req_lock = lock;
    #1;
    total++;
    if (req_rdy !== exp_rdy) begin
      bad++;
      $display("FAIL %s: req_rdy=%b want %b", name, req_rdy, exp_rdy);
    end else begin
      $display("%s: req_rdy=%b ok", name, req_rdy);
    end
    if (!r && exp_rdy != 4'b0000) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (exp_rdy[i]) begin
          e.d = data[i*DAT_W +: DAT_W];
          e.s = IDX_W'(i);
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // Check registered outputs just after the next rising edge.
  task automatic check_out(input string name, input logic [7:0] ed,
                           input logic eu, input logic [1:0] es);
    @(posedge clk);
    #1;
    total++;
    if (data_out !== ed || data_upd !== eu || last_src !== es) begin
      bad++;
      $display("FAIL %s: data=%h upd=%b src=%0d want data=%h upd=%b src=%0d",
               name, data_out, data_upd, last_src, ed, eu, es);
    end else begin
      $display("%s: data=%h upd=%b src=%0d ok", name, data_out, data_upd, last_src);
    end
  endtask

  initial begin
    rst      = 1'b1;
    req_vld  = 4'b1111;
    req_data = 32'h55555555;
    req_lock = 4'b0000;

    // Reset held with all requesters valid: no grants, registers cleared.
    for (int i = 0; i < 3; i++) step("rst_hold", 1'b1, 4'b1111, 32'h55555555, 4'b0000, 4'b0000);
    check_out("rst_regs", 8'h00, 1'b0, 2'd0);

    // Fairness: first cycle after reset arbitrates normally from ptr=0.
    for (int k = 0; k < 8; k++) begin
      logic [3:0] g;
      g = 4'b0001 << (k % 4);
      step("fair", 1'b0, 4'b1111, 32'h13121110, 4'b0000, g);
    end

    // Single requester 2: granted, ptr moves to 3.
    step("single", 1'b0, 4'b0100, 32'h00A50000, 4'b0000, 4'b0100);
    check_out("single_regs", 8'hA5, 1'b1, 2'd2);
    step("idle", 1'b0, 4'b0000, 32'h00000000, 4'b0000, 4'b0000);
    check_out("hold_regs", 8'hA5, 1'b0, 2'd2);

    // Wrap/skip from ptr=3: req 0, then req 1, ptr ends at 2.
    step("wrap0", 1'b0, 4'b0011, 32'h0000B2B1, 4'b0000, 4'b0001);
    step("wrap1", 1'b0, 4'b0011, 32'h0000B2B1, 4'b0000, 4'b0010);
    step("ptr2",  1'b0, 4'b1111, 32'hC3C2C1C0, 4'b0000, 4'b0100);

    // Reset on the same cycle as a would-be write of 0x77: discarded.
    step("rst_mid", 1'b1, 4'b1111, 32'h77777777, 4'b0000, 4'b0000);
    check_out("rst_mid_regs", 8'h00, 1'b0, 2'd0);
    step("after_rst", 1'b0, 4'b1111, 32'hD3D2D1D0, 4'b0000, 4'b0001);

`ifdef SHARED_REG_ARB_LOCK_EN
    // ptr=1. Req 1 writes with lock: LOCKED, owner=1, ptr=2.
    step("lock_wr", 1'b0, 4'b0010, 32'h00003C00, 4'b0010, 4'b0010);
    for (int i = 0; i < 5; i++)
      step("locked", 1'b0, 4'b0101, 32'h00E200E0, 4'b0010, 4'b0000);
    // Dropping lock still blocks this cycle; the edge reopens.
    step("unlock", 1'b0, 4'b0101, 32'h00E200E0, 4'b0000, 4'b0000);
    step("reopen", 1'b0, 4'b0101, 32'h00E200E0, 4'b0000, 4'b0100);
`endif

    step("drain", 1'b0, 4'b0000, 32'h00000000, 4'b0000, 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_empty: %0d expected writes never seen, want 0", exp_q.size());
    end else begin
      $display("queue_empty: ok");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_reg_arb.md
# shared_reg_arb

Round-robin write arbiter in front of a shared data register: up to NUM_REQ requesters compete each cycle to load the register, one winner is accepted per cycle, and the register contents plus the winning source index are exported to downstream logic. It is the standard front end wherever a single configuration or status register is written by several independent agents.

## Interface
Parameters:
- DAT_W, 8, register and per-requester data width.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- IDX_W, $clog2(NUM_REQ), source index width; derived, never overridden.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- req_vld  input  NUM_REQ  per-requester write request.
- req_data  input  NUM_REQ*DAT_W  flattened write data; requester i occupies bits [i*DAT_W +: DAT_W].
- req_rdy  output  NUM_REQ  one-hot grant, combinational from req_vld and internal state. A write completes when req_vld[i] & req_rdy[i].
- data_out  output  DAT_W  shared register contents.
- data_upd  output  1  one-cycle pulse in the cycle after a write, aligned with the new data_out.
- last_src  output  IDX_W  index of the requester that performed the most recent write.
- req_lock  input  NUM_REQ  ownership hold request; present only with SHARED_REG_ARB_LOCK_EN.

## Operation
- Round-robin pointer ptr (IDX_W bits):
  - Winner = first i with req_vld[i] high, searching ptr, ptr+1, … modulo NUM_REQ.
  - req_rdy has exactly one bit set when any req_vld is high, and is all zero otherwise.
- On a write edge:
  - data_out <= winner data.
  - last_src <= winner.
  - data_upd <= 1.
  - ptr <= winner+1; wraps to 0 after NUM_REQ-1.
- On an edge with no request: data_out, last_src and ptr hold; data_upd <= 0.
- req_rdy never asserts without the matching req_vld.
- Requesters may drop req_vld at any time without a grant; there is no data retention on the request side.
- Reset values: data_out=0, data_upd=0, last_src=0, ptr=0, req_rdy=0 while rst is high, FSM=OPEN.
- rst has priority over any simultaneous write; the write is discarded.

## Timing
- Arbitration is zero latency: the grant is visible in the same cycle as req_vld.
- data_out, data_upd and last_src update one cycle after the accepted write.
- Throughput: one write per cycle; back-to-back writes from different requesters are allowed.
- Single active requester holding req_vld: it is granted every cycle, and ptr moves to its index+1 each time.
- All requesters active: grants rotate 0,1,…,NUM_REQ-1,0 with no gaps.
- The first cycle after rst deasserts is a normal arbitration cycle.

## Configuration
- Macro: SHARED_REG_ARB_LOCK_EN.
- Defined:
  - Adds the req_lock port and a two-state FSM, OPEN and LOCKED, with register owner (IDX_W bits).
  - OPEN -> LOCKED when the accepted write has req_lock[winner]=1; owner <= winner.
  - In LOCKED, only owner can be granted; all other req_rdy bits are 0 and ptr holds.
  - LOCKED -> OPEN on the first edge where req_lock[owner]=0, whether or not a write occurs. If that edge is an owner write, the write is accepted and ptr <= owner+1.
  - rst forces OPEN and owner=0.
- Undefined: no req_lock port, no FSM; pure round-robin.

## Structure
- Package shared_reg_arb_pkg holds:
  - the FSM state typedef (OPEN, LOCKED);
  - the NUM_REQ bounds constants;
  - a function for the rotating first-one search.
- Sub-module rr_pick: combinational rotating priority picker.
  - Inputs: request vector, ptr, optional mask.
  - Outputs: one-hot grant, winner index, any-valid.
- The register, pointer and FSM live in shared_reg_arb. Storage uses synchronous reset, so base_reg is not instantiated.

## Test plan
- Reset: hold rst 3 cycles with all req_vld=1 -> req_rdy=0, data_out=0x00, data_upd=0, last_src=0.
- Single requester: req_vld=4'b0100, data 0xA5 -> req_rdy=4'b0100 that cycle; next cycle data_out=0xA5, last_src=2, data_upd=1.
- Fairness: all four valid for 8 cycles with data 0x10+i -> grant order 0,1,2,3,0,1,2,3, and data_out follows 0x10..0x13 twice.
- Wrap/skip: ptr=3, req_vld=4'b0011 -> grant req 0, then req 1; ptr ends at 2.
- Reset mid-stream: assert rst in the same cycle as a granted write of 0x77 -> data_out stays 0, ptr=0.
- Lock (macro on): req 1 writes 0x3C with lock=1, then req 0 and req 2 valid for 5 cycles -> only req 1 granted; dropping req_lock[1] for one edge returns to OPEN, and the next grant goes to req 2.
